mem_stage_unit: RTL
===================

// Module: mem_stage_unit
// PURPOSE
//  Memory-stage consumer of the E->M pipeline register outputs. Drives a data-memory
//  request/ready bus for loads/stores and stalls the front pipeline while it waits.
//  Delivers the M->W pipeline register (load data, ALU result, control) to writeback.
//  Sits between the E/M register and the register-file writeback mux.
// PARAMETERS
//  DATA_W      32   width of ALU result, store data, load data, memory address
//  WA_W        3    register-file write-address width
//  TIMEOUT     16   max BUSY cycles waiting for mem_ready before abort (>=2)
// PORTS
//  clk          in   1       clock, all state updates on posedge
//  rst          in   1       synchronous reset, active-high
//  PCSrcM       in   1       branch/PC-write control from E/M register
//  RegWriteM    in   1       register write enable from E/M register
//  MemWriteM    in   1       store request from E/M register
//  MemtoRegM    in   1       load request (writeback selects memory data)
//  ALUResultM   in   DATA_W  byte address for memory ops / result for ALU ops
//  WriteDataM   in   DATA_W  store data
//  WA3M         in   WA_W    destination register
//  StallM       out  1       hold E/M and earlier stages (drives their enables low)
//  mem_req      out  1       memory request valid (registered)
//  mem_we       out  1       1 = store, 0 = load (registered, valid with mem_req)
//  mem_addr     out  DATA_W  word-aligned address {ALUResultM[DATA_W-1:2],2'b00}
//  mem_wdata    out  DATA_W  store data (registered)
//  mem_ready    in   1       memory completes request this cycle; mem_rdata valid
//  mem_rdata    in   DATA_W  load data
//  PCSrcW, RegWriteW, MemtoRegW  out 1  control to writeback stage
//  ReadDataW    out  DATA_W  captured load data
//  ALUOutW      out  DATA_W  pass-through ALU result
//  WA3W         out  WA_W    destination register
//  err_o        out  1       sticky: timeout or misaligned access; cleared only by rst
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high (rst sampled on posedge clk).
//  - Reset: state IDLE, all outputs 0, timeout counter 0, err_o 0.
//  - FSM IDLE -> BUSY -> DONE -> IDLE.
//  - IDLE, no mem op (MemWriteM=MemtoRegM=0): StallM=0; W register loads M inputs
//    next edge (1-cycle latency, identical to plain pipeline register).
//  - IDLE, mem op: StallM=1 combinationally; latch addr/wdata/we/control; go BUSY;
//    W register loads a bubble (RegWriteW=0, PCSrcW=0, MemtoRegW=0).
//  - BUSY: mem_req=1, StallM=1, bubble into W; counter increments each cycle.
//    * mem_ready=1: capture mem_rdata (loads only), drop mem_req next edge, go DONE.
//    * counter==TIMEOUT-1 with no mem_ready: abort, set err_o, ReadData=0, go DONE.
//  - DONE: StallM=0; W register loads latched control+data; go IDLE. Store retires
//    with RegWriteW as presented (normally 0). Min load/store latency: 3 cycles
//    from entry to W valid with mem_ready on first BUSY cycle.
//  - MemWriteM and MemtoRegM both 1: treated as store; err_o set.
//  - ALUResultM[1:0]!=0 on mem op: access proceeds aligned; err_o set.
//  - mem_ready outside BUSY: ignored.
//  - rst mid-BUSY: request dropped same edge, state IDLE, in-flight op discarded.
//  - Counter saturates at TIMEOUT-1; cleared on entry to BUSY.
// STRUCTURE
//  - Shared pkg vp_pkg: mem_state_t enum {IDLE,BUSY,DONE}, DATA_W/WA_W constants,
//    mw_ctrl_t struct {PCSrc,RegWrite,MemtoReg}.
//  - Sub-module reg_mw: M->W register with load-bubble select; FSM/counter in top.
// TESTING
//  1 ALU op: RegWriteM=1,ALUResultM=0x0000_0042,WA3M=3 -> next edge ALUOutW=0x42,
//    RegWriteW=1, WA3W=3, StallM=0 throughout.
//  2 Load addr 0x100, mem_ready on 2nd BUSY cycle with rdata 0xDEAD_BEEF -> StallM
//    high 3 cycles, mem_addr=0x100, ReadDataW=0xDEADBEEF, MemtoRegW=1.
//  3 Store addr 0x204 data 0x1234_5678 -> mem_we=1, mem_wdata=0x12345678 while
//    mem_req; RegWriteW=0; err_o=0.
//  4 Load with mem_ready never asserted, TIMEOUT=16 -> mem_req drops after 16
//    cycles, err_o=1, ReadDataW=0, StallM released.
//  5 Misaligned load 0x103 -> mem_addr=0x100, err_o=1 sticky until rst.
//  6 rst asserted during BUSY -> next edge mem_req=0, StallM=0, all W outputs 0.

Source files
------------

// File: rtl/mem_stage_unit_pkg.sv
// Shared types and constants for the memory stage: FSM state encoding, default widths and
// the control bundle carried from M to W.
package mem_stage_unit_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_WA_W   = 3;

    typedef logic [1:0] mem_state_t;

    localparam mem_state_t StIdle = 2'd0;
    localparam mem_state_t StBusy = 2'd1;
    localparam mem_state_t StDone = 2'd2;

    typedef struct packed {
        logic pc_src;
        logic reg_write;
        logic mem_to_reg;
    } mw_ctrl_t;

endpackage

// File: rtl/mem_stage_unit_if.sv
// Data-memory request/ready bus between the memory stage (master) and the memory (slave).
interface mem_stage_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_stage_unit_reg_mw.sv
// M->W pipeline register; a bubble clears the whole entry so stalled cycles retire nothing.
module mem_stage_unit_reg_mw
    import mem_stage_unit_pkg::*;
#(
    parameter int unsigned DATA_W = MEM_DATA_W,
    parameter int unsigned WA_W   = MEM_WA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bubble_i,
    input  mw_ctrl_t          ctrl_i,
    input  logic [DATA_W-1:0] read_data_i,
    input  logic [DATA_W-1:0] alu_out_i,
    input  logic [WA_W-1:0]   wa3_i,
    output mw_ctrl_t          ctrl_o,
    output logic [DATA_W-1:0] read_data_o,
    output logic [DATA_W-1:0] alu_out_o,
    output logic [WA_W-1:0]   wa3_o
);

    mw_ctrl_t          ctrl_d, ctrl_q;
    logic [DATA_W-1:0] read_data_d, read_data_q;
    logic [DATA_W-1:0] alu_out_d, alu_out_q;
    logic [WA_W-1:0]   wa3_d, wa3_q;

    always_comb begin
        ctrl_d      = ctrl_i;
        read_data_d = read_data_i;
        alu_out_d   = alu_out_i;
        wa3_d       = wa3_i;
        if (bubble_i) begin
            ctrl_d      = '0;
            read_data_d = '0;
            alu_out_d   = '0;
            wa3_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q      <= '0;
            read_data_q <= '0;
            alu_out_q   <= '0;
            wa3_q       <= '0;
        end else begin
            ctrl_q      <= ctrl_d;
            read_data_q <= read_data_d;
            alu_out_q   <= alu_out_d;
            wa3_q       <= wa3_d;
        end
    end

    assign ctrl_o      = ctrl_q;
    assign read_data_o = read_data_q;
    assign alu_out_o   = alu_out_q;
    assign wa3_o       = wa3_q;

endmodule

// File: rtl/mem_stage_unit.sv
// Memory stage: issues one load/store at a time on the memory bus, stalls the front pipeline
// until it completes or times out, then retires the op into the M->W register.
module mem_stage_unit
    import mem_stage_unit_pkg::*;
#(
    parameter int unsigned DATA_W  = MEM_DATA_W,
    parameter int unsigned WA_W    = MEM_WA_W,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              PCSrcM,
    input  logic              RegWriteM,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [DATA_W-1:0] ALUResultM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic [WA_W-1:0]   WA3M,
    output logic              StallM,
    mem_stage_unit_if.master  mem,
    output logic              PCSrcW,
    output logic              RegWriteW,
    output logic              MemtoRegW,
    output logic [DATA_W-1:0] ReadDataW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [WA_W-1:0]   WA3W,
    output logic              err_o
);

    localparam int unsigned     CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    mem_state_t        state_d, state_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              req_d, req_q;
    logic              we_d, we_q;
    logic [DATA_W-1:0] addr_d, addr_q;
    logic [DATA_W-1:0] wdata_d, wdata_q;
    mw_ctrl_t          ctrl_d, ctrl_q;
    logic [DATA_W-1:0] alu_d, alu_q;
    logic [WA_W-1:0]   wa3_d, wa3_q;
    logic [DATA_W-1:0] rdata_d, rdata_q;
    logic              err_d, err_q;

    logic              mem_op;
    logic              bad_op;
    logic              w_bubble;
    mw_ctrl_t          w_ctrl;
    logic [DATA_W-1:0] w_alu, w_rdata;
    logic [WA_W-1:0]   w_wa3;
    mw_ctrl_t          w_ctrl_out;

    assign mem_op = MemWriteM | MemtoRegM;
    assign bad_op = (MemWriteM & MemtoRegM) | (|ALUResultM[1:0]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ctrl_d  = ctrl_q;
        alu_d   = alu_q;
        wa3_d   = wa3_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        StallM            = 1'b0;
        w_bubble          = 1'b1;
        w_ctrl.pc_src     = PCSrcM;
        w_ctrl.reg_write  = RegWriteM;
        w_ctrl.mem_to_reg = MemtoRegM;
        w_alu             = ALUResultM;
        w_wa3             = WA3M;
        w_rdata           = '0;

        case (state_q)
            StIdle: begin
                if (mem_op) begin
                    StallM            = 1'b1;
                    state_d           = StBusy;
                    cnt_d             = '0;
                    req_d             = 1'b1;
                    we_d              = MemWriteM;
                    addr_d            = {ALUResultM[DATA_W-1:2], 2'b00};
                    wdata_d           = WriteDataM;
                    // A load+store combination is retired as a store, so no load data.
                    ctrl_d.pc_src     = PCSrcM;
                    ctrl_d.reg_write  = RegWriteM;
                    ctrl_d.mem_to_reg = MemtoRegM & ~MemWriteM;
                    alu_d             = ALUResultM;
                    wa3_d             = WA3M;
                    rdata_d           = '0;
                    if (bad_op) begin
                        err_d = 1'b1;
                    end
                end else begin
                    w_bubble = 1'b0;
                end
            end
            StBusy: begin
                StallM = 1'b1;
                cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                if (mem.mem_ready) begin
                    if (!we_q) begin
                        rdata_d = mem.mem_rdata;
                    end
                    req_d   = 1'b0;
                    state_d = StDone;
                end else if (cnt_q == CNT_MAX) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    req_d   = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                w_bubble = 1'b0;
                w_ctrl   = ctrl_q;
                w_alu    = alu_q;
                w_wa3    = wa3_q;
                w_rdata  = rdata_q;
                state_d  = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ctrl_q  <= '0;
            alu_q   <= '0;
            wa3_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ctrl_q  <= ctrl_d;
            alu_q   <= alu_d;
            wa3_q   <= wa3_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    mem_stage_unit_reg_mw #(
        .DATA_W (DATA_W),
        .WA_W   (WA_W)
    ) u_reg_mw (
        .clk         (clk),
        .rst         (rst),
        .bubble_i    (w_bubble),
        .ctrl_i      (w_ctrl),
        .read_data_i (w_rdata),
        .alu_out_i   (w_alu),
        .wa3_i       (w_wa3),
        .ctrl_o      (w_ctrl_out),
        .read_data_o (ReadDataW),
        .alu_out_o   (ALUOutW),
        .wa3_o       (WA3W)
    );

    assign PCSrcW        = w_ctrl_out.pc_src;
    assign RegWriteW     = w_ctrl_out.reg_write;
    assign MemtoRegW     = w_ctrl_out.mem_to_reg;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign err_o         = err_q;

endmodule
